// File: rtl/hex_display_regs.sv
// Memory-mapped display register bank feeding SevenSegmentControl: four 16-bit
// registers, leading-zero blanking and a per-digit blink timer, all outputs registered.
module hex_display_regs #(
    parameter int unsigned BLINK_HALF = 25000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic [3:0]  in7,
    output logic [3:0]  in6,
    output logic [3:0]  in5,
    output logic [3:0]  in4,
    output logic [3:0]  in3,
    output logic [3:0]  in2,
    output logic [3:0]  in1,
    output logic [3:0]  in0,
    output logic [7:0]  turn_on
);

    localparam logic [1:0]       ADDR_DATA_LO = 2'd0;
    localparam logic [1:0]       ADDR_DATA_HI = 2'd1;
    localparam logic [1:0]       ADDR_CTRL    = 2'd2;
    localparam logic [1:0]       ADDR_BMASK   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(BLINK_HALF - 32'd1);

    logic [15:0]      data_lo_q, data_lo_d;
    logic [15:0]      data_hi_q, data_hi_d;
    logic [7:0]       en_mask_q, en_mask_d;
    logic             lzb_q, lzb_d;
    logic             blink_en_q, blink_en_d;
    logic [7:0]       blink_mask_q, blink_mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [31:0]      nib_q, nib_d;
    logic [7:0]       turn_on_q, turn_on_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic [31:0]      digits_s;
    logic [7:0]       lz_mask_s;
    logic             zero_above_s;
    logic [7:0]       blink_off_s;
    logic [15:0]      rd_mux_s;
    logic             wr_lo_s, wr_hi_s, wr_ctrl_s, wr_bmask_s;

    // Next-state logic: register writes, blink timer, display masks and read mux.
    always_comb begin
        wr_lo_s    = wr_en && (addr == ADDR_DATA_LO);
        wr_hi_s    = wr_en && (addr == ADDR_DATA_HI);
        wr_ctrl_s  = wr_en && (addr == ADDR_CTRL);
        wr_bmask_s = wr_en && (addr == ADDR_BMASK);

        data_lo_d    = wr_lo_s    ? wr_data        : data_lo_q;
        data_hi_d    = wr_hi_s    ? wr_data        : data_hi_q;
        en_mask_d    = wr_ctrl_s  ? wr_data[7:0]   : en_mask_q;
        lzb_d        = wr_ctrl_s  ? wr_data[8]     : lzb_q;
        blink_en_d   = wr_ctrl_s  ? wr_data[9]     : blink_en_q;
        blink_mask_d = wr_bmask_s ? wr_data[7:0]   : blink_mask_q;

        // While disabled the timer sits at count 0 / visible phase, so the
        // enabling edge always starts a full visible half-period.
        if (!blink_en_q) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end

        digits_s     = {data_hi_q, data_lo_q};
        lz_mask_s    = 8'hFF;
        zero_above_s = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above_s = zero_above_s & (digits_s[i*4 +: 4] == 4'h0);
            lz_mask_s[i] = ~(lzb_q & zero_above_s);
        end

        blink_off_s = (blink_en_q && !phase_q) ? blink_mask_q : 8'h00;
        turn_on_d   = en_mask_q & lz_mask_s & ~blink_off_s;
        nib_d       = digits_s;

        case (addr)
            ADDR_DATA_LO: rd_mux_s = data_lo_q;
            ADDR_DATA_HI: rd_mux_s = data_hi_q;
            ADDR_CTRL:    rd_mux_s = {6'b000000, blink_en_q, lzb_q, en_mask_q};
            ADDR_BMASK:   rd_mux_s = {8'h00, blink_mask_q};
            default:      rd_mux_s = 16'h0000;
        endcase
        rd_data_d  = rd_en ? rd_mux_s : rd_data_q;
        rd_valid_d = rd_en;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_lo_q    <= 16'h0000;
            data_hi_q    <= 16'h0000;
            en_mask_q    <= 8'h00;
            lzb_q        <= 1'b0;
            blink_en_q   <= 1'b0;
            blink_mask_q <= 8'h00;
            cnt_q        <= {CNT_W{1'b0}};
            phase_q      <= 1'b1;
            nib_q        <= 32'h0000_0000;
            turn_on_q    <= 8'h00;
            rd_data_q    <= 16'h0000;
            rd_valid_q   <= 1'b0;
        end else begin
            data_lo_q    <= data_lo_d;
            data_hi_q    <= data_hi_d;
            en_mask_q    <= en_mask_d;
            lzb_q        <= lzb_d;
            blink_en_q   <= blink_en_d;
            blink_mask_q <= blink_mask_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            nib_q        <= nib_d;
            turn_on_q    <= turn_on_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign in0      = nib_q[3:0];
    assign in1      = nib_q[7:4];
    assign in2      = nib_q[11:8];
    assign in3      = nib_q[15:12];
    assign in4      = nib_q[19:16];
    assign in5      = nib_q[23:20];
    assign in6      = nib_q[27:24];
    assign in7      = nib_q[31:28];
    assign turn_on  = turn_on_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
